// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports with
// optional same-cycle bypass, and a busy scoreboard for pending port-1 results.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     err_idle_wr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;
  logic                         err_q, err_d;
  logic                         wr0_ok, wr1_ok, set_ok, cnt_inc, cnt_dec;

  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign set_ok = rsv_en && (rsv_addr != '0);

  always_comb begin
    // Port 0 is applied last so it wins an address collision.
    mem_d = mem_q;
    if (wr1_ok) mem_d[wa1] = wd1;
    if (wr0_ok) mem_d[wa0] = wd0;
    mem_d[0] = '0;

    busy_d = busy_q;
    if (wr1_ok) busy_d[wa1] = 1'b0;
    if (set_ok) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;

    // Incremental population count; a reserve on the released address cancels the release.
    cnt_inc    = set_ok && !busy_q[rsv_addr];
    cnt_dec    = wr1_ok && busy_q[wa1] && !(set_ok && (rsv_addr == wa1));
    busy_cnt_d = busy_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);

    err_d = err_q | (wr1_ok && !busy_q[wa1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      if ((BYPASS != 0) && (addr != '0)) begin
        if (we0 && (wa0 == addr))      data = wd0;
        else if (we1 && (wa1 == addr)) data = wd1;
      end
      if (reset) data = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    // Busy is registered state only; a release shows up the cycle after the edge.
    assign rd_busy[k] = !reset && busy_q[addr];
  end

  assign busy_cnt    = busy_cnt_q;
  assign err_idle_wr = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and are
// compared against an array-based model of the register file and scoreboard.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_b, rd_data_n;
  logic [NR-1:0]     rd_busy_b, rd_busy_n;
  logic              we0, we1, rsv_en;
  logic [AW-1:0]     wa0, wa1, rsv_addr;
  logic [DW-1:0]     wd0, wd1;
  logic [AW:0]       cnt_b, cnt_n;
  logic              err_b, err_n;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_err;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt_b), .err_idle_wr(err_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nob (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt_n), .err_idle_wr(err_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Applies one rising edge: port 1 first, port 0 overrides, reserve overrides release.
  task automatic model_update();
    if (we1 && wa1 != 0) begin
      if (!m_busy[wa1]) m_err = 1'b1;
      m_reg[wa1]  = wd1;
      m_busy[wa1] = 1'b0;
    end
    if (we0 && wa0 != 0) m_reg[wa0] = wd0;
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
    if (reset || a == 0) return '0;
    if (byp && we0 && int'(wa0) == a) return wd0;
    if (byp && we1 && int'(wa1) == a) return wd1;
    return m_reg[a];
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check_all(input string ctx);
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("%s byp rd_data%0d r%0d", ctx, k, a), 64'(rd_data_b[k*DW +: DW]), 64'(exp_rd(a, 1'b1)));
      chk($sformatf("%s nob rd_data%0d r%0d", ctx, k, a), 64'(rd_data_n[k*DW +: DW]), 64'(exp_rd(a, 1'b0)));
      chk($sformatf("%s byp rd_busy%0d r%0d", ctx, k, a), 64'(rd_busy_b[k]), 64'(!reset && m_busy[a]));
      chk($sformatf("%s nob rd_busy%0d r%0d", ctx, k, a), 64'(rd_busy_n[k]), 64'(!reset && m_busy[a]));
    end
    chk($sformatf("%s byp busy_cnt", ctx), 64'(cnt_b), 64'(m_cnt()));
    chk($sformatf("%s nob busy_cnt", ctx), 64'(cnt_n), 64'(m_cnt()));
    chk($sformatf("%s byp err_idle_wr", ctx), 64'(err_b), 64'(m_err));
    chk($sformatf("%s nob err_idle_wr", ctx), 64'(err_n), 64'(m_err));
  endtask

  // Entered just after a rising edge; checks the combinational view mid-cycle.
  task automatic cycle(input string ctx);
    @(negedge clk);
    check_all(ctx);
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    rsv_en = 0; rsv_addr = '0;
    rd_addr = {AW'(r1), AW'(r0)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    model_reset();
    idle(0, 0);

    // r0 is untouchable, and everything is ignored while reset is high
    we0 = 1; wa0 = 0; wd0 = 32'hDEADBEEF;
    we1 = 1; wa1 = 0; wd1 = 32'hDEADBEEF;
    rsv_en = 1; rsv_addr = 0;
    cycle("rst_r0");
    idle(5, 0);
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 5;
    cycle("rst_hold");
    reset = 1'b0;
    idle(0, 5);
    cycle("rst_after");
    we0 = 1; wa0 = 0; wd0 = 32'hDEADBEEF;
    we1 = 1; wa1 = 0; wd1 = 32'hDEADBEEF;
    rsv_en = 1; rsv_addr = 0;
    cycle("r0_live");
    idle(0, 0);
    cycle("r0_after");

    // bypass vs stored view
    idle(5, 0);
    we0 = 1; wa0 = 5; wd0 = 32'h12345678;
    cycle("bypass");
    idle(5, 0);
    cycle("bypass_next");

    // scoreboard
    idle(3, 4); rsv_en = 1; rsv_addr = 3;
    cycle("sb_rsv3");
    idle(3, 4); rsv_en = 1; rsv_addr = 4;
    cycle("sb_rsv4");
    idle(3, 4);
    cycle("sb_two");
    idle(3, 4); we1 = 1; wa1 = 3; wd1 = 32'h33;
    cycle("sb_rel3");
    idle(3, 4);
    cycle("sb_one");
    idle(4, 3); rsv_en = 1; rsv_addr = 4; we1 = 1; wa1 = 4; wd1 = 32'h44;
    cycle("sb_rsv_rel4");
    idle(4, 3);
    cycle("sb_keep");

    // port-1 write to an idle register
    idle(9, 0); we1 = 1; wa1 = 9; wd1 = 32'h99;
    cycle("idle_wr");
    idle(9, 0);
    cycle("idle_wr_after");
    idle(9, 4);
    cycle("idle_persist");

    // write conflict on r7
    idle(7, 0);
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA0000;
    we1 = 1; wa1 = 7; wd1 = 32'h5555FFFF;
    cycle("conflict");
    idle(7, 0);
    cycle("conflict_after");

    // async reset between edges
    idle(1, 2); we0 = 1; wa0 = 1; wd0 = 32'h11; rsv_en = 1; rsv_addr = 2;
    cycle("pre_async_wr");
    idle(1, 2);
    cycle("pre_async");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    cycle("in_rst");
    reset = 1'b0;
    idle(1, 2);
    cycle("post_async");

    // randomized traffic over the low 16 registers to force collisions
    for (int it = 0; it < 400; it++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      we0 = ($urandom_range(0, 2) == 0); wa0 = AW'($urandom_range(0, 15)); wd0 = $urandom;
      we1 = ($urandom_range(0, 2) == 0); wa1 = AW'($urandom_range(0, 15)); wd1 = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom_range(0, 15));
      rd_addr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      if (it % 97 == 50 && !reset) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_async");
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle MIPS datapath and its pipelined successor. It provides NUM_RD combinational read ports and two write ports: port 0 for ALU/fast results, port 1 for load and multi-cycle results. Optional same-cycle write-to-read bypass is included. A per-register busy scoreboard marks registers awaiting a port-1 result, so the decode stage can stall on pending operands. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and the error flag
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  busy bit of each addressed register
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0: enable, address, data
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1: enable, address, data; also releases busy
- rsv_en, rsv_addr  in  1/ADDR_W  reserve (set busy) on a destination register
- busy_cnt  out  ADDR_W+1  number of registers currently busy
- err_idle_wr  out  1  sticky flag: port 1 wrote a register that was not busy

## Operation
- Storage is 2**ADDR_W entries of DATA_W bits. Entry 0 always reads 0, is never written and is never busy.
- Writes:
  - On the rising edge, port 0 writes wd0 to wa0 if we0 and wa0≠0.
  - Port 1 writes wd1 to wa1 if we1 and wa1≠0.
  - If both ports target the same nonzero address in one cycle, port 0's data is stored; port 1's data is discarded.
- Reads are combinational: rd_data[k] = entry[rd_addr[k]].
- Bypass (BYPASS=1, reset low, address ≠0):
  - If we0 and wa0 = rd_addr[k], rd_data[k] = wd0.
  - Else if we1 and wa1 = rd_addr[k], rd_data[k] = wd1.
  - Otherwise the stored value is returned.
- Scoreboard: one busy bit per entry, updated on the rising edge.
  - Set: rsv_en and rsv_addr≠0.
  - Clear: we1 at wa1, unless the same cycle reserves the same address. Reserve wins, and busy stays 1.
  - A port-0 write never changes busy.
- rd_busy[k] = busy[rd_addr[k]], registered state only; it is not bypassed, so a release is visible the next cycle.
- busy_cnt is a registered population count, kept equal to the number of set busy bits after every edge:
  - increments on a set of a non-busy register;
  - decrements on a clear of a busy register;
  - stays unchanged when a set and a clear hit the same already-busy address.
- err_idle_wr is set on an edge where we1, wa1≠0 and busy[wa1]=0 before that edge. It stays set until reset. The write itself still occurs.

## Timing
- Reset values: all entries 0, all busy 0, busy_cnt 0, err_idle_wr 0. rd_data is 0 and rd_busy is 0 for any address while reset is high.
- Bypass is gated off during reset, and writes and reserves are ignored during reset.
- Reset deasserted mid-cycle: the first write takes effect on the first rising edge with reset low.
- Write latency:
  - BYPASS=1: data is readable in the same cycle through the bypass, and from storage after the edge.
  - BYPASS=0: data is readable from the cycle after the edge.
- Reserve/release latency: one edge. Reserve in cycle n makes rd_busy high in cycle n+1.
- Reset asserted mid-operation immediately clears all state. Pending reservations are lost.

## Test plan
- Reset/zero:
  - Stimulus: assert reset, then write 0xDEADBEEF to r0 on both ports and reserve r0.
  - Required: r0 reads 0, rd_busy=0, busy_cnt=0, err_idle_wr=0.
- Bypass:
  - BYPASS=1: we0 writes 0x12345678 to r5 with rd_addr[0]=5 → rd_data[0]=0x12345678 in the same cycle.
  - BYPASS=0: the same stimulus → old value 0 in the same cycle and 0x12345678 the next cycle.
- Write conflict: we0 (r7, 0xAAAA0000) and we1 (r7, 0x5555FFFF) in the same cycle → r7 reads 0xAAAA0000 afterwards.
- Scoreboard:
  - Reserve r3, r4 → busy_cnt=2 and rd_busy set for r3, r4.
  - we1 to r3 → busy_cnt=1.
  - rsv r4 with we1 r4 in the same cycle → r4 stays busy and busy_cnt=1.
- Idle write: we1 to r9 when r9 is not busy → err_idle_wr=1 after the edge, r9 updated, and the flag persists until reset.
- Async reset mid-run: set r1=0x11, reserve r2, then pulse reset between clock edges → all outputs 0 immediately, without waiting for a clock edge.
